// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Brief    : Fetch stage - owns the PC, reads the combinational instruction ROM
//            and queues {pc, instr, fault} entries for decode (valid/ready).
// Revision : 1.0  initial release
// ============================================================================
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_AW   = 12,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_fault,
    output logic [31:0] fetch_count
);
    localparam int               c_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W:0] c_DEPTH   = (c_PTR_W + 1)'(DEPTH);
    localparam logic [31:0]      c_NOP     = 32'h0000_0013;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FPUSH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t              r_state;
    logic [31:0]         r_pc;
    logic [31:0]         r_fetch_count;
    logic [31:0]         r_pc_mem    [DEPTH];
    logic [31:0]         r_instr_mem [DEPTH];
    logic [DEPTH-1:0]    r_fault_mem;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W:0]    r_count;

    logic w_pop;
    logic w_push_ok;
    logic w_misaligned;
    logic w_out_range;
    logic w_bad_pc;
    logic w_fetch;
    logic w_fpush;
    logic w_push;

    // A ROM of 2**30 words or more covers the whole 32-bit space.
    generate
        if (ROM_AW >= 30) begin : g_full_range
            assign w_out_range = 1'b0;
        end else begin : g_limited_range
            assign w_out_range = |r_pc[31:ROM_AW+2];
        end
    endgenerate

    assign w_misaligned = (r_pc[1:0] != 2'b00);
    assign w_bad_pc     = w_misaligned | w_out_range;
    assign w_pop        = (r_count != '0) & out_ready;
    assign w_push_ok    = (r_count < c_DEPTH) | w_pop;
    assign w_fetch      = (r_state == S_RUN) & ~w_bad_pc & w_push_ok;
    assign w_fpush      = (r_state == S_FPUSH) & w_push_ok;
    assign w_push       = w_fetch | w_fpush;

    assign rom_addr    = r_pc;
    assign out_valid   = (r_count != '0);
    assign out_pc      = r_pc_mem[r_rd_ptr];
    assign out_instr   = r_instr_mem[r_rd_ptr];
    assign out_fault   = r_fault_mem[r_rd_ptr];
    assign fetch_count = r_fetch_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_fault_mem   <= '0;
            // Clearing storage makes the head read back as zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_state  <= S_RUN;
            r_pc     <= redirect_pc;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc_mem[r_wr_ptr]    <= r_pc;
                r_instr_mem[r_wr_ptr] <= w_fpush ? c_NOP : rom_data;
                r_fault_mem[r_wr_ptr] <= w_fpush;
                r_wr_ptr              <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_RUN: begin
                    if (w_bad_pc) begin
                        r_state <= S_FPUSH;
                    end else if (w_fetch) begin
                        r_pc          <= r_pc + 32'd4;
                        r_fetch_count <= r_fetch_count + 32'd1;
                    end
                end
                S_FPUSH: begin
                    if (w_fpush) begin
                        r_state <= S_HALT;
                    end
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_unit
// Brief    : Self-checking bench for ifetch_unit: directed scenarios with literal
//            expectations plus randomized traffic against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ifetch_unit;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          ROM_AW    = 12;
    localparam int          DEPTH     = 2;
    localparam logic [31:0] ROM_BYTES = 32'h0000_4000;

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc     = RESET_PC;
    logic [31:0] m_fcnt   = '0;
    bit          m_fpend  = 0;
    bit          m_halt   = 0;
    bit          m_live   = 0;
    bit          m_reset  = 0;

    ifetch_unit #(
        .RESET_PC (RESET_PC),
        .ROM_AW   (ROM_AW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_fault      (out_fault),
        .fetch_count    (fetch_count)
    );

    // ROM word i holds the value i.
    function automatic logic [31:0] rom_of(input logic [31:0] a);
        return (a / 32'd4) % (32'd1 << ROM_AW);
    endfunction

    assign rom_data = rom_of(rom_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour for one rising edge, evaluated on the pre-edge inputs.
    task automatic model_step();
        int   sz;
        bit   pop;
        bit   room;
        bit   do_push;
        ent_t e;
        m_live  = 1;
        m_reset = 0;
        if (!rst_n) begin
            mq.delete();
            m_pc = RESET_PC; m_fcnt = '0; m_fpend = 0; m_halt = 0; m_reset = 1;
        end else if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc; m_fpend = 0; m_halt = 0;
        end else begin
            sz      = mq.size();
            pop     = (sz != 0) && out_ready;
            room    = (sz < DEPTH) || pop;
            do_push = 0;
            e       = '{pc: 32'h0, instr: 32'h0, fault: 1'b0};
            if (!m_halt) begin
                if (m_fpend) begin
                    if (room) begin
                        e = '{pc: m_pc, instr: 32'h0000_0013, fault: 1'b1};
                        do_push = 1; m_halt = 1; m_fpend = 0;
                    end
                end else if ((m_pc % 4 != 0) || (m_pc >= ROM_BYTES)) begin
                    m_fpend = 1;
                end else if (room) begin
                    e = '{pc: m_pc, instr: rom_of(m_pc), fault: 1'b0};
                    do_push = 1; m_pc = m_pc + 32'd4; m_fcnt = m_fcnt + 32'd1;
                end
            end
            if (pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("m_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
                chk("m_rom_addr", rom_addr, m_pc);
                chk("m_fetch_count", fetch_count, m_fcnt);
                if (mq.size() != 0) begin
                    chk("m_pc", out_pc, mq[0].pc);
                    chk("m_instr", out_instr, mq[0].instr);
                    chk("m_fault", {31'b0, out_fault}, {31'b0, mq[0].fault});
                end else if (m_reset) begin
                    chk("m_rst_pc", out_pc, 32'h0);
                    chk("m_rst_instr", out_instr, 32'h0);
                    chk("m_rst_fault", {31'b0, out_fault}, 32'h0);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    task automatic head(input string name, input logic v, input logic [31:0] pc,
                        input logic [31:0] ins, input logic f);
        chk({name, "_valid"}, {31'b0, out_valid}, {31'b0, v});
        if (v) begin
            chk({name, "_pc"}, out_pc, pc);
            chk({name, "_instr"}, out_instr, ins);
            chk({name, "_fault"}, {31'b0, out_fault}, {31'b0, f});
        end
    endtask

    initial begin
        int kind;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;

        // Reset and streaming at one instruction per cycle
        tick(3);
        head("rst", 1'b0, 0, 0, 1'b0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_fc", fetch_count, 32'h0);
        chk("rst_addr", rom_addr, RESET_PC);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            head("stream", 1'b1, 32'(4 * i), 32'(i), 1'b0);
            chk("stream_fc", fetch_count, 32'(i + 1));
        end

        // Backpressure fills the queue and stalls the PC
        rst_n = 1'b0; out_ready = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(5);
        head("bp_full", 1'b1, 32'h0, 32'h0, 1'b0);
        chk("bp_addr", rom_addr, 32'h8);
        chk("bp_fc", fetch_count, 32'd2);
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick(1);
            head("bp_drain", 1'b1, 32'(4 * i), 32'(i), 1'b0);
        end

        // Redirect while full and popping
        out_ready = 1'b0;
        tick(3);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick(1);
        redirect_valid = 1'b0;
        head("redir_flush", 1'b0, 0, 0, 1'b0);
        chk("redir_addr", rom_addr, 32'h100);
        tick(1);
        head("redir_tgt", 1'b1, 32'h100, 32'h40, 1'b0);

        // Misaligned target: single fault entry then halt
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick(1);
        redirect_valid = 1'b0;
        tick(1);
        head("mis_wait", 1'b0, 0, 0, 1'b0);
        tick(1);
        head("mis_fault", 1'b1, 32'h102, 32'h13, 1'b1);
        tick(1);
        head("mis_halt", 1'b0, 0, 0, 1'b0);
        tick(6);
        head("mis_halt2", 1'b0, 0, 0, 1'b0);
        chk("mis_addr", rom_addr, 32'h102);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick(1);
        redirect_valid = 1'b0;
        tick(1);
        head("mis_resume", 1'b1, 32'h0, 32'h0, 1'b0);

        // Last ROM word then out-of-range fault
        redirect_valid = 1'b1; redirect_pc = 32'h3FFC;
        tick(1);
        redirect_valid = 1'b0;
        tick(1);
        head("end_good", 1'b1, 32'h3FFC, 32'hFFF, 1'b0);
        tick(1);
        head("end_gap", 1'b0, 0, 0, 1'b0);
        tick(1);
        head("end_fault", 1'b1, 32'h4000, 32'h13, 1'b1);
        tick(1);
        head("end_halt", 1'b0, 0, 0, 1'b0);

        // Reset beats a same-cycle redirect
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick(1);
        redirect_valid = 1'b0;
        tick(4);
        rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick(1);
        rst_n = 1'b1; redirect_valid = 1'b0;
        head("rr_rst", 1'b0, 0, 0, 1'b0);
        chk("rr_instr", out_instr, 32'h0);
        chk("rr_fc", fetch_count, 32'h0);
        chk("rr_addr", rom_addr, RESET_PC);
        tick(1);
        head("rr_restart", 1'b1, RESET_PC, 32'h0, 1'b0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            out_ready      = ($urandom_range(0, 9) < 7);
            rst_n          = ($urandom_range(0, 199) != 0);
            redirect_valid = ($urandom_range(0, 29) == 0);
            kind           = int'($urandom_range(0, 3));
            case (kind)
                0:       redirect_pc = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
                1:       redirect_pc = {18'h0, 12'($urandom_range(0, 4095)), 2'($urandom_range(1, 3))};
                2:       redirect_pc = 32'h3FE0 + 32'(4 * $urandom_range(0, 7));
                default: redirect_pc = $urandom;
            endcase
            tick(1);
        end
        rst_n = 1'b1; redirect_valid = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
